// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory access sequencer.
package mem_pkg;

  typedef enum logic [1:0] {
    BYTE   = 2'd0,
    HALF   = 2'd1,
    WORD   = 2'd2,
    DOUBLE = 2'd3
  } mem_size_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_WRITE = 3'd2,
    S_RESP  = 3'd3,
    S_ERR   = 3'd4
  } mau_state_t;

  localparam int BYTE_W  = 8;
  localparam int HALF_W  = 16;
  localparam int WORD_W  = 32;
  localparam int DWORD_W = 64;

  // An access is aligned when its byte offset is a multiple of its size.
  function automatic logic is_aligned(input logic [2:0] offset, input mem_size_t size);
    logic ok;
    case (size)
      BYTE:    ok = 1'b1;
      HALF:    ok = (offset[0] == 1'b0);
      WORD:    ok = (offset[1:0] == 2'b00);
      DOUBLE:  ok = (offset == 3'b000);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane extraction (loads) and lane merge (partial stores).
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [63:0] rdata_i,
  input  logic [63:0] wdata_i,
  input  logic [2:0]  offset_i,
  input  mem_size_t   size_i,
  input  logic        unsigned_i,
  output logic [63:0] ext_o,
  output logic [63:0] merged_o
);

  logic [BYTE_W-1:0] byte_s;
  logic [HALF_W-1:0] half_s;
  logic [WORD_W-1:0] word_s;

  assign byte_s = rdata_i[{offset_i, 3'b000} +: BYTE_W];
  assign half_s = rdata_i[{offset_i[2:1], 4'b0000} +: HALF_W];
  assign word_s = rdata_i[{offset_i[2], 5'b00000} +: WORD_W];

  // Extend the selected lane and splice store data into the read doubleword.
  always_comb begin
    ext_o    = 64'd0;
    merged_o = rdata_i;
    case (size_i)
      BYTE: begin
        ext_o = unsigned_i ? {56'd0, byte_s} : {{56{byte_s[7]}}, byte_s};
        merged_o[{offset_i, 3'b000} +: BYTE_W] = wdata_i[BYTE_W-1:0];
      end
      HALF: begin
        ext_o = unsigned_i ? {48'd0, half_s} : {{48{half_s[15]}}, half_s};
        merged_o[{offset_i[2:1], 4'b0000} +: HALF_W] = wdata_i[HALF_W-1:0];
      end
      WORD: begin
        ext_o = unsigned_i ? {32'd0, word_s} : {{32{word_s[31]}}, word_s};
        merged_o[{offset_i[2], 5'b00000} +: WORD_W] = wdata_i[WORD_W-1:0];
      end
      DOUBLE: begin
        ext_o    = rdata_i;
        merged_o = wdata_i;
      end
      default: begin
        ext_o    = 64'd0;
        merged_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store sequencer with read-modify-write for partial stores
// and misalignment reporting.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        misaligned,
  output logic [63:0] mem_addr,
  output logic        mem_wr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);

  localparam int CNT_W = $clog2(MEM_LAT + 2);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT);

  mau_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      addr_q;
  mem_size_t        size_q;
  logic             uns_q;
  logic             write_q;
  logic [63:0]      wdata_q;
  logic [63:0]      rdata_q;
  logic [63:0]      ext_s;
  logic [63:0]      merged_s;
  logic             accept_s;
  logic             sample_s;

  assign accept_s = req_valid && (state_q == S_IDLE);
  assign sample_s = (state_q == S_WAIT) && (cnt_q == '0);

  mem_lane_align u_align (
    .rdata_i    (mem_rdata),
    .wdata_i    (wdata_q),
    .offset_i   (addr_q[2:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .ext_o      (ext_s),
    .merged_o   (merged_s)
  );

  // State and latency counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the counter gives MEM_LAT+1 WAIT cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (!is_aligned(req_addr[2:0], mem_size_t'(req_size))) begin
            state_d = S_ERR;
          end else if (req_write && (mem_size_t'(req_size) == DOUBLE)) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = write_q ? S_WRITE : S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control outputs decoded from the registered state.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    misaligned = 1'b0;
    mem_wr     = 1'b0;
    case (state_q)
      S_IDLE:  req_ready = 1'b1;
      S_WAIT:  req_ready = 1'b0;
      S_WRITE: begin
        mem_wr     = 1'b1;
        resp_valid = 1'b1;
      end
      S_RESP:  resp_valid = 1'b1;
      S_ERR: begin
        resp_valid = 1'b1;
        misaligned = 1'b1;
      end
      default: req_ready = 1'b0;
    endcase
  end

  // Request latch, write register (store data then merged line) and load result.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= 64'd0;
      size_q  <= BYTE;
      uns_q   <= 1'b0;
      write_q <= 1'b0;
      wdata_q <= 64'd0;
      rdata_q <= 64'd0;
    end else if (accept_s) begin
      addr_q  <= req_addr;
      size_q  <= mem_size_t'(req_size);
      uns_q   <= req_unsigned;
      write_q <= req_write;
      wdata_q <= req_wdata;
    end else if (sample_s) begin
      if (write_q) begin
        wdata_q <= merged_s;
      end else begin
        rdata_q <= ext_s;
      end
    end
  end

  assign mem_addr   = {addr_q[63:3], 3'b000};
  assign mem_wdata  = wdata_q;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: directed vector table, reset/back-to-back sequences and
// randomized requests against a byte-level reference memory model.
module tb_mem_access_unit;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        misaligned;
  logic [63:0] mem_addr;
  logic        mem_wr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_LAT(LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .misaligned   (misaligned),
    .mem_addr     (mem_addr),
    .mem_wr       (mem_wr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Memory: LAT-stage read pipeline, write port from DUT plus a bench fill port.
  logic [63:0] mem [0:255];
  logic [63:0] rd_pipe [0:LAT-1];
  logic        fill_we = 1'b0;
  logic [7:0]  fill_idx = 8'd0;
  logic [63:0] fill_val = 64'd0;
  logic [63:0] ref_mem [0:255];

  always @(posedge clk) begin
    rd_pipe[0] <= mem[mem_addr[10:3]];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (fill_we) mem[fill_idx] <= fill_val;
    else if (mem_wr) mem[mem_addr[10:3]] <= mem_wdata;
  end
  assign mem_rdata = rd_pipe[LAT-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic aligned(input logic [63:0] a, input logic [1:0] sz);
    return (a % (64'd1 << sz)) == 64'd0;
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] dw, input logic [2:0] off,
                                             input logic [1:0] sz, input logic u);
    int n = 1 << sz;
    logic [63:0] v = 64'd0;
    logic neg = dw[(int'(off) + n) * 8 - 1];
    for (int i = 0; i < 8; i++) begin
      if (i < n) v[i*8 +: 8] = dw[(int'(off) + i) * 8 +: 8];
      else if (!u && neg) v[i*8 +: 8] = 8'hFF;
    end
    return v;
  endfunction

  function automatic logic [63:0] model_store(input logic [63:0] dw, input logic [2:0] off,
                                              input logic [1:0] sz, input logic [63:0] wd);
    logic [63:0] v = dw;
    for (int i = 0; i < (1 << sz); i++) v[(int'(off) + i) * 8 +: 8] = wd[i*8 +: 8];
    return v;
  endfunction

  // Issue one request and observe it until resp_valid (latency counted from acceptance cycle).
  task automatic run_req(input string tag, input logic w, input logic [1:0] sz, input logic u,
                         input logic [63:0] a, input logic [63:0] wd,
                         output int lat, output int nwr, output logic mis,
                         output logic [63:0] rd, output logic [63:0] wdat, output logic [63:0] wadr);
    @(negedge clk);
    check({tag, " ready_at_issue"}, {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_wdata = ~wd; req_addr = ~a;
    lat = 1; nwr = 0; mis = 1'b0; rd = 64'd0; wdat = 64'd0; wadr = 64'd0;
    while (lat < 30) begin
      if (mem_wr) begin
        nwr++; wdat = mem_wdata; wadr = mem_addr;
      end
      if (resp_valid) break;
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) begin
      n_total++;
      $display("FAIL %s timeout: no resp_valid within %0d cycles", tag, lat);
    end
    mis = misaligned;
    rd  = resp_rdata;
    check({tag, " ready_low_at_resp"}, {63'd0, req_ready}, 64'd0);
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [63:0] addr;
    logic [63:0] wd;
    logic        mis;
    logic [63:0] exp_rd;
    logic [63:0] exp_wd;
  } vec_t;

  vec_t vecs [13];
  logic [63:0] last_load = 64'd0;

  // Apply one observed transaction's checks given the expected results.
  task automatic judge(input string tag, input logic w, input logic [1:0] sz, input logic [63:0] a,
                       input logic exp_mis, input logic [63:0] exp_rd, input logic [63:0] exp_wd,
                       input int lat, input int nwr, input logic mis,
                       input logic [63:0] rd, input logic [63:0] wdat, input logic [63:0] wadr);
    int exp_lat;
    int exp_nwr;
    exp_lat = exp_mis ? 1 : ((w && sz == 2'd3) ? 1 : 2 + LAT);
    exp_nwr = (w && !exp_mis) ? 1 : 0;
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " mem_wr_count"}, 64'(nwr), 64'(exp_nwr));
    check({tag, " misaligned"}, {63'd0, mis}, {63'd0, exp_mis});
    check({tag, " resp_rdata"}, rd, (!w && !exp_mis) ? exp_rd : last_load);
    if (!w && !exp_mis) last_load = exp_rd;
    if (w && !exp_mis) begin
      check({tag, " mem_wdata"}, wdat, exp_wd);
      check({tag, " mem_addr"}, wadr, {a[63:3], 3'b000});
      ref_mem[a[10:3]] = exp_wd;
    end
  endtask

  initial begin
    int lat, nwr;
    logic mis;
    logic [63:0] rd, wdat, wadr, v;

    vecs[0]  = '{1'b0, 2'd0, 1'b0, 64'h101, 64'h0, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 64'h0};
    vecs[1]  = '{1'b0, 2'd1, 1'b1, 64'h100, 64'h0, 1'b0, 64'h0000_0000_0000_80FF, 64'h0};
    vecs[2]  = '{1'b1, 2'd0, 1'b0, 64'h203, 64'hAB, 1'b0, 64'h0, 64'h1122_3344_AB66_7788};
    vecs[3]  = '{1'b1, 2'd3, 1'b0, 64'h208, 64'hDEAD_BEEF_0123_4567, 1'b0, 64'h0, 64'hDEAD_BEEF_0123_4567};
    vecs[4]  = '{1'b0, 2'd2, 1'b0, 64'h102, 64'h0, 1'b1, 64'h0, 64'h0};
    vecs[5]  = '{1'b0, 2'd3, 1'b1, 64'h208, 64'h0, 1'b0, 64'hDEAD_BEEF_0123_4567, 64'h0};
    vecs[6]  = '{1'b0, 2'd2, 1'b0, 64'h20C, 64'h0, 1'b0, 64'hFFFF_FFFF_DEAD_BEEF, 64'h0};
    vecs[7]  = '{1'b1, 2'd1, 1'b0, 64'h203, 64'h1234, 1'b1, 64'h0, 64'h0};
    vecs[8]  = '{1'b0, 2'd0, 1'b1, 64'h203, 64'h0, 1'b0, 64'h0000_0000_0000_00AB, 64'h0};
    vecs[9]  = '{1'b1, 2'd1, 1'b0, 64'h206, 64'hFFFF_CAFE, 1'b0, 64'h0, 64'hCAFE_3344_AB66_7788};
    vecs[10] = '{1'b0, 2'd1, 1'b0, 64'h206, 64'h0, 1'b0, 64'hFFFF_FFFF_FFFF_CAFE, 64'h0};
    vecs[11] = '{1'b0, 2'd2, 1'b1, 64'h204, 64'h0, 1'b0, 64'h0000_0000_CAFE_3344, 64'h0};
    vecs[12] = '{1'b1, 2'd2, 1'b0, 64'h204, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'h0, 64'h9ABC_DEF0_AB66_7788};

    // Reset held with a (double store) request pending: it must be ignored.
    reset = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_size = 2'd3; req_unsigned = 1'b0;
    req_addr = 64'h48; req_wdata = 64'hFFFF_0000_FFFF_0000;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (i == 32'h20)      v = 64'h0000_0000_0000_80FF;
      else if (i == 32'h40) v = 64'h1122_3344_5566_7788;
      else                  v = {$urandom, $urandom};
      fill_we = 1'b1; fill_idx = 8'(i); fill_val = v; ref_mem[i] = v;
      if (i > 250) check("reset_ignores_req", {62'd0, resp_valid, mem_wr}, 64'd0);
    end
    @(negedge clk);
    fill_we = 1'b0;
    check("reset req_ready", {63'd0, req_ready}, 64'd1);
    check("reset resp_valid", {63'd0, resp_valid}, 64'd0);
    check("reset misaligned", {63'd0, misaligned}, 64'd0);
    check("reset mem_wr", {63'd0, mem_wr}, 64'd0);
    check("reset resp_rdata", resp_rdata, 64'd0);
    check("reset mem_addr", mem_addr, 64'd0);
    check("reset mem_wdata", mem_wdata, 64'd0);
    req_valid = 1'b0;
    reset = 1'b0;

    for (int k = 0; k < 13; k++) begin
      run_req($sformatf("vec%0d", k), vecs[k].w, vecs[k].sz, vecs[k].u, vecs[k].addr, vecs[k].wd,
              lat, nwr, mis, rd, wdat, wadr);
      judge($sformatf("vec%0d", k), vecs[k].w, vecs[k].sz, vecs[k].addr, vecs[k].mis,
            vecs[k].exp_rd, vecs[k].exp_wd, lat, nwr, mis, rd, wdat, wadr);
    end

    // Reset during WAIT of a half store: abandoned, no write, no response.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
    req_addr = 64'h212; req_wdata = 64'h5555;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_mid in_wait ready", {63'd0, req_ready}, 64'd0);
    reset = 1'b1;
    nwr = 0;
    for (int c = 0; c < 5; c++) begin
      if (mem_wr || resp_valid) nwr++;
      @(negedge clk);
      reset = 1'b0;
    end
    check("rst_mid no_activity", 64'(nwr), 64'd0);
    check("rst_mid ready_after", {63'd0, req_ready}, 64'd1);

    // Back-to-back loads: the second is issued the cycle after the first response.
    run_req("b2b_first", 1'b0, 2'd2, 1'b1, 64'h200, 64'h0, lat, nwr, mis, rd, wdat, wadr);
    judge("b2b_first", 1'b0, 2'd2, 64'h200, 1'b0, 64'h0000_0000_AB66_7788, 64'h0,
          lat, nwr, mis, rd, wdat, wadr);
    run_req("b2b_second", 1'b0, 2'd3, 1'b0, 64'h210, 64'h0, lat, nwr, mis, rd, wdat, wadr);
    judge("b2b_second", 1'b0, 2'd3, 64'h210, 1'b0, ref_mem[8'h42], 64'h0,
          lat, nwr, mis, rd, wdat, wadr);

    // Randomized requests against the reference model (full 64-bit addresses exercise truncation).
    for (int r = 0; r < 60; r++) begin
      logic        w;
      logic [1:0]  sz;
      logic        u;
      logic [63:0] a;
      logic [63:0] wd;
      logic        exp_mis;
      logic [63:0] exp_rd;
      logic [63:0] exp_wd;
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      u  = 1'($urandom_range(0, 1));
      a  = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      wd = {$urandom, $urandom};
      exp_mis = !aligned(a, sz);
      exp_rd  = exp_mis ? 64'd0 : model_load(ref_mem[a[10:3]], a[2:0], sz, u);
      exp_wd  = exp_mis ? 64'd0 : model_store(ref_mem[a[10:3]], a[2:0], sz, wd);
      run_req($sformatf("rnd%0d", r), w, sz, u, a, wd, lat, nwr, mis, rd, wdat, wadr);
      judge($sformatf("rnd%0d", r), w, sz, a, exp_mis, exp_rd, exp_wd, lat, nwr, mis, rd, wdat, wadr);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
